// File: rtl/rst_tag_ctrl.sv
//==============================================================================
// Module      : rst_tag_ctrl
// Description : ROB tag allocator and register-status-table write/clear driver.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rst_tag_ctrl #(
    parameter int TAG_W = 5,
    parameter int REG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             disp_req,
    input  logic             disp_wr,
    input  logic [REG_W-1:0] disp_rd,
    output logic             disp_gnt,
    output logic [TAG_W-1:0] disp_tag,
    input  logic             cmt_valid,
    input  logic             flush,
    output logic [REG_W-1:0] Waddr_rst,
    output logic [TAG_W-1:0] Wdata_rst,
    output logic             Wen_rst,
    output logic [TAG_W-1:0] RB_tag_rst,
    output logic             RB_valid_rst,
    output logic             rst_clear,
    output logic [TAG_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             cmt_err
);

    localparam int           DEPTH       = 1 << TAG_W;
    localparam logic [TAG_W:0] C_DEPTH_CNT = (TAG_W + 1)'(DEPTH);

    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [DEPTH-1:0] r_wr_flag;

    logic             w_grant;
    logic             w_commit;
    logic [TAG_W:0]   w_count_nxt;

    // Grant and commit both see the registered full/empty of this cycle, so a
    // retirement cannot make room for a dispatch in the same cycle.
    assign w_grant  = disp_req & ~full & ~flush;
    assign w_commit = cmt_valid & ~empty & ~flush;
    assign disp_gnt = w_grant;
    assign disp_tag = r_tail;

    always_comb begin
        w_count_nxt = count;
        if (flush)
            w_count_nxt = '0;
        else if (w_grant && !w_commit)
            w_count_nxt = count + 1'b1;
        else if (w_commit && !w_grant)
            w_count_nxt = count - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_wr_flag    <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            cmt_err      <= 1'b0;
            Waddr_rst    <= '0;
            Wdata_rst    <= '0;
            Wen_rst      <= 1'b0;
            RB_tag_rst   <= '0;
            RB_valid_rst <= 1'b0;
            rst_clear    <= 1'b0;
        end else begin
            count     <= w_count_nxt;
            full      <= (w_count_nxt == C_DEPTH_CNT);
            empty     <= (w_count_nxt == '0);
            rst_clear <= flush;
            Wen_rst      <= w_grant & disp_wr;
            RB_valid_rst <= w_commit & r_wr_flag[r_head];

            if (cmt_valid && empty)
                cmt_err <= 1'b1;

            if (flush) begin
                r_head    <= '0;
                r_tail    <= '0;
                r_wr_flag <= '0;
            end else begin
                if (w_grant) begin
                    r_tail            <= r_tail + TAG_W'(1);
                    r_wr_flag[r_tail] <= disp_wr;
                    if (disp_wr) begin
                        Waddr_rst <= disp_rd;
                        Wdata_rst <= r_tail;
                    end
                end
                if (w_commit) begin
                    r_head <= r_head + TAG_W'(1);
                    if (r_wr_flag[r_head])
                        RB_tag_rst <= r_head;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rst_tag_ctrl.sv
//==============================================================================
// Module      : tb_rst_tag_ctrl
// Description : Directed scoreboard bench for rst_tag_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rst_tag_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       disp_req = 1'b0;
    logic       disp_wr = 1'b0;
    logic [4:0] disp_rd = '0;
    logic       disp_gnt;
    logic [4:0] disp_tag;
    logic       cmt_valid = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] Waddr_rst;
    logic [4:0] Wdata_rst;
    logic       Wen_rst;
    logic [4:0] RB_tag_rst;
    logic       RB_valid_rst;
    logic       rst_clear;
    logic [5:0] count;
    logic       full;
    logic       empty;
    logic       cmt_err;

    int ntests = 0;
    int nfail  = 0;

    logic [9:0] wq[$];   // {addr, data} expected on the RST write port
    logic [4:0] rq[$];   // expected retire-clear tags
    int         fq = 0;  // expected rst_clear pulses

    always #5 clk = ~clk;

    rst_tag_ctrl #(.TAG_W(5), .REG_W(5)) dut (
        .clock(clk), .reset(rst_n),
        .disp_req(disp_req), .disp_wr(disp_wr), .disp_rd(disp_rd),
        .disp_gnt(disp_gnt), .disp_tag(disp_tag),
        .cmt_valid(cmt_valid), .flush(flush),
        .Waddr_rst(Waddr_rst), .Wdata_rst(Wdata_rst), .Wen_rst(Wen_rst),
        .RB_tag_rst(RB_tag_rst), .RB_valid_rst(RB_valid_rst),
        .rst_clear(rst_clear), .count(count), .full(full), .empty(empty),
        .cmt_err(cmt_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        logic [9:0] e;
        logic [4:0] t;
        if (Wen_rst) begin
            ntests++;
            if (wq.size() == 0) begin
                nfail++;
                $display("FAIL wen_unexpected: got addr %0d data %0d expected no write", Waddr_rst, Wdata_rst);
            end else begin
                e = wq.pop_front();
                if ({Waddr_rst, Wdata_rst} !== e) begin
                    nfail++;
                    $display("FAIL wen_payload: got addr %0d data %0d expected addr %0d data %0d",
                             Waddr_rst, Wdata_rst, e[9:5], e[4:0]);
                end
            end
        end
        if (RB_valid_rst) begin
            ntests++;
            if (rq.size() == 0) begin
                nfail++;
                $display("FAIL rb_unexpected: got tag %0d expected no clear", RB_tag_rst);
            end else begin
                t = rq.pop_front();
                if (RB_tag_rst !== t) begin
                    nfail++;
                    $display("FAIL rb_tag: got %0d expected %0d", RB_tag_rst, t);
                end
            end
        end
        if (rst_clear) begin
            ntests++;
            if (fq == 0) begin
                nfail++;
                $display("FAIL clear_unexpected: got rst_clear 1 expected 0");
            end else begin
                fq--;
            end
        end
    end

    // One cycle of stimulus; entered and left at posedge+1 with inputs idle.
    task automatic cyc(input bit req, input bit wr, input int rd, input bit cmt,
                       input bit fl, input bit exp_gnt, input int exp_tag, input int exp_rb);
        disp_req = req; disp_wr = wr; disp_rd = 5'(rd);
        cmt_valid = cmt; flush = fl;
        if (exp_gnt && wr && !fl) wq.push_back({5'(rd), 5'(exp_tag)});
        if (exp_rb >= 0) rq.push_back(5'(exp_rb));
        if (fl) fq++;
        @(negedge clk);
        chk("disp_gnt", int'(disp_gnt), int'(exp_gnt));
        if (req) chk("disp_tag", int'(disp_tag), exp_tag);
        @(posedge clk);
        #1;
        disp_req = 0; disp_wr = 0; disp_rd = '0; cmt_valid = 0; flush = 0;
    endtask

    task automatic status(input string nm, input int c, input bit f, input bit e);
        chk({nm, "_count"}, int'(count), c);
        chk({nm, "_full"},  int'(full),  int'(f));
        chk({nm, "_empty"}, int'(empty), int'(e));
    endtask

    task automatic reset_vals(input string nm);
        status(nm, 0, 0, 1);
        chk({nm, "_wen"},     int'(Wen_rst),      0);
        chk({nm, "_rbv"},     int'(RB_valid_rst), 0);
        chk({nm, "_clr"},     int'(rst_clear),    0);
        chk({nm, "_cmt_err"}, int'(cmt_err),      0);
        chk({nm, "_tag"},     int'(disp_tag),     0);
        chk({nm, "_waddr"},   int'(Waddr_rst),    0);
        chk({nm, "_rbtag"},   int'(RB_tag_rst),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_vals("reset");
        rst_n = 1'b1;

        // First dispatch writes r7 with tag 0
        cyc(1, 1, 7, 0, 0, 1, 0, -1);
        status("one", 1, 0, 0);

        // Fill the ROB; tag 3 allocated without a register write
        for (int i = 1; i < 32; i++) cyc(1, (i != 3), i, 0, 0, 1, i, -1);
        status("fill", 32, 1, 0);

        // 33rd request refused, tail wrapped to 0
        cyc(1, 1, 8, 0, 0, 0, 0, -1);
        status("over", 32, 1, 0);

        // Full: commit does not free a slot for a same-cycle dispatch
        cyc(1, 1, 8, 1, 0, 0, 0, 0);
        status("fullcmt", 31, 0, 0);
        cyc(1, 1, 9, 0, 0, 1, 0, -1);
        status("refill", 32, 1, 0);

        // Retire tags 1..4; tag 3 has no register so no clear strobe
        for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 0, 0, 0, (i == 3) ? -1 : i);
        status("retire", 28, 0, 0);

        // Grant and commit on the same register in one cycle
        cyc(1, 1, 5, 1, 0, 1, 1, 5);
        status("both", 28, 0, 0);

        // Flush with competing dispatch and commit
        cyc(1, 1, 6, 1, 1, 0, 2, -1);
        status("flush1", 0, 0, 1);

        for (int i = 0; i < 5; i++) cyc(1, 1, 10 + i, 0, 0, 1, i, -1);
        status("five", 5, 0, 0);
        cyc(1, 1, 6, 1, 1, 0, 5, -1);
        status("flush2", 0, 0, 1);

        // After flush: only tag 3 carries a register write
        for (int i = 0; i < 4; i++) cyc(1, (i == 3), 12, 0, 0, 1, i, -1);
        status("alloc4", 4, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0, (i == 3) ? 3 : -1);
        status("drain", 0, 0, 1);
        chk("cmt_err_clean", int'(cmt_err), 0);

        // Commit while empty is ignored but sticky-flagged
        cyc(0, 0, 0, 1, 0, 0, 0, -1);
        status("emptycmt", 0, 0, 1);
        chk("cmt_err_set", int'(cmt_err), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, -1);
        chk("cmt_err_sticky", int'(cmt_err), 1);

        // Asynchronous reset mid-burst aborts the pending write strobe
        cyc(1, 0, 0, 0, 0, 1, 4, -1);
        cyc(1, 0, 0, 0, 0, 1, 5, -1);
        disp_req = 1; disp_wr = 1; disp_rd = 5'd20;
        @(posedge clk);
        #1;
        disp_req = 0; disp_wr = 0; disp_rd = '0;
        rst_n = 1'b0;
        #1;
        reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 1, 7, 0, 0, 1, 0, -1);
        status("postrst", 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        chk("fq_drained", fq, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire
